instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the 6-stage 16-bit pipeline. Owns the program counter and drives the instruction memory byte address. Reassembles the returned high/low bytes into a 16-bit instruction and registers it, with its PC, into the IF/ID pipeline register. Honours stall from hazard detection and redirect/flush from branch/jump resolution.

## Interface
Parameters:
- RESET_PC, 16'h0000, byte address fetched first after reset
- IMEM_WORDS, 101, number of 16-bit words in instruction memory; legal PCs are 0 .. 2*IMEM_WORDS-2

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- i_mem_addr  out  16  byte address to instruction memory, equals pc
- i_mem_data_h  in  8  instruction bits [15:8] for i_mem_addr
- i_mem_data_l  in  8  instruction bits [7:0] for i_mem_addr
- stall  in  1  hold PC and IF/ID contents
- redirect  in  1  branch/jump taken; load br_target, flush IF/ID
- br_target  in  16  redirect byte address
- if_id_instr  out  16  registered instruction
- if_id_pc  out  16  registered PC of if_id_instr
- if_id_pc_plus2  out  16  if_id_pc + 2, for JAL/JLR link
- if_id_valid  out  1  IF/ID holds a real instruction
- misalign_err  out  1  one-cycle pulse: redirect target had bit0 = 1
- fetch_oob  out  1  level: fetch halted, PC out of range
- fetch_count  out  16  count of instructions captured into IF/ID

## Operation
- Instruction = {i_mem_data_h, i_mem_data_l}, sampled combinationally from the current pc.
- FSM states: BOOT, RUN, OOB.
  - BOOT: entered on reset. Memory output is undefined during reset, so nothing is captured. PC stays at RESET_PC. Unconditionally goes to RUN next cycle, unless a redirect arrives (see below).
  - RUN: fetch and capture every non-stalled cycle.
  - OOB: entered from RUN when pc > 2*IMEM_WORDS-2. PC is held and IF/ID is loaded with a bubble. Only a redirect leaves OOB.
- Priority per cycle: reset > redirect > stall > normal fetch.
  - Reset: pc = RESET_PC, state = BOOT, if_id_* = 0, fetch_count = 0, misalign_err = 0.
  - Redirect, in any state, including while stalled: pc = {br_target[15:1], 1'b0}; if_id_valid = 0; state = RUN (or OOB if the target is out of range). misalign_err = br_target[0].
  - Stall without redirect: pc, IF/ID and fetch_count all hold.
  - Normal fetch in RUN with pc in range:
    - if_id_instr = instruction, if_id_pc = pc, if_id_pc_plus2 = pc + 2, if_id_valid = 1
    - pc = pc + 2; fetch_count increments
- pc + 2 wraps modulo 2^16, but the OOB check triggers before any wrap for IMEM_WORDS < 32768.
- fetch_count wraps 16'hFFFF -> 0 and increments only on a valid capture.
- With if_id_valid = 0, if_id_instr/pc hold their previous values; downstream qualifies on valid.

## Timing
- i_mem_addr is registered (it is pc); instruction memory returns data in the same cycle.
- Fetch-to-IF/ID latency: 1 clock.
- First valid IF/ID occurs at the 2nd rising edge after reset deasserts (BOOT costs 1 bubble).
- Redirect takes effect on the next edge:
  - the instruction at br_target appears in IF/ID one edge later
  - the wrong-path IF/ID entry is killed at the redirect edge
- Stall asserted in cycle N: the IF/ID values from edge N-1 remain through every stalled cycle.
- fetch_oob asserts the cycle after entering OOB and clears the cycle after the redirect edge.
- Reset asserted mid-operation: all outputs reach reset values at that edge, regardless of stall/redirect.

## Structure
- Shared package `pipeline_pkg`: ADDR_W=16, INSTR_W=16, fetch FSM state encodings (BOOT/RUN/OOB), IF/ID field widths.
- Optional sub-module `pc_next_sel`: combinational next-pc mux (reset/redirect/stall/+2) plus the range check. The rest stays in instruction_fetch.

## Test plan
- Reset release, no stall, memory words 0..2 = 16'h1722, 16'h1F28, 16'h1B8A -> IF/ID valid at the 2nd edge: pc 0/2/4, instructions in order, fetch_count = 3 after the 4th edge.
- Stall held 3 cycles while IF/ID = (pc 6) -> IF/ID and i_mem_addr frozen for 3 cycles; pc 8 captured on the first edge after stall drops.
- Redirect to 16'h001C at pc 12, same cycle as stall -> next edge: pc = 28, if_id_valid = 0; next edge: IF/ID pc = 28, pc_plus2 = 30.
- Redirect to 16'h0013 -> misalign_err pulses once, pc = 16'h0012.
- Free-run with IMEM_WORDS = 4 -> after pc 6 is captured: fetch_oob = 1, if_id_valid = 0 stays low; redirect to 0 resumes fetch and clears fetch_oob.
- Assert reset during a redirect cycle -> pc = RESET_PC, state BOOT, if_id_valid = 0, fetch_count = 0, misalign_err = 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 16-bit pipeline.
// Holds fetch FSM encodings and the IF/ID bundle layout.
package pipeline_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    OOB  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus2;
    logic               valid;
  } if_id_t;

  function automatic logic addr_oob(
    input logic [ADDR_W-1:0] a,
    input int                words
  );
    return int'(a) > (2 * words - 2);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux for the fetch stage plus instruction memory range checks.
// Priority: reset, redirect, stall/hold, sequential advance.
module pc_next_sel
  import pipeline_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          IMEM_WORDS = 101
) (
  input  logic        reset,
  input  logic        redirect,
  input  logic        advance,
  input  logic [15:0] br_target,
  input  logic [15:0] pc,
  output logic [15:0] pc_next,
  output logic        target_oob,
  output logic        pc_oob
);

  logic [15:0] redirect_pc;

  assign redirect_pc = {br_target[15:1], 1'b0};
  assign target_oob  = addr_oob(redirect_pc, IMEM_WORDS);
  assign pc_oob      = addr_oob(pc, IMEM_WORDS);

  always_comb begin
    pc_next = pc;
    if (!reset)
      pc_next = RESET_PC;
    else if (redirect)
      pc_next = redirect_pc;
    else if (advance)
      pc_next = 16'(pc + 16'd2);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reassembles memory bytes, loads IF/ID.
// Handles stall, redirect/flush and out-of-range halt.
module instruction_fetch
  import pipeline_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          IMEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] i_mem_addr,
  input  logic [7:0]  i_mem_data_h,
  input  logic [7:0]  i_mem_data_l,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] br_target,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic        fetch_oob,
  output logic [15:0] fetch_count
);

  fetch_state_e state;
  if_id_t       if_id;
  logic [15:0]  pc;
  logic [15:0]  pc_next;
  logic         target_oob;
  logic         pc_oob;
  logic         advance;

  assign advance = (state == RUN) && !pc_oob && !stall && !redirect;

  pc_next_sel #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc_next_sel (
    .reset      (reset),
    .redirect   (redirect),
    .advance    (advance),
    .br_target  (br_target),
    .pc         (pc),
    .pc_next    (pc_next),
    .target_oob (target_oob),
    .pc_oob     (pc_oob)
  );

  always_ff @(posedge clk) begin
    pc <= pc_next;
    if (!reset) begin
      state        <= BOOT;
      if_id        <= '0;
      fetch_count  <= '0;
      misalign_err <= 1'b0;
      fetch_oob    <= 1'b0;
    end else if (redirect) begin
      state        <= target_oob ? OOB : RUN;
      if_id.valid  <= 1'b0;
      misalign_err <= br_target[0];
      fetch_oob    <= target_oob;
    end else begin
      misalign_err <= 1'b0;
      if (!stall) begin
        unique case (state)
          BOOT: state <= RUN;
          RUN: begin
            if (pc_oob) begin
              state       <= OOB;
              if_id.valid <= 1'b0;
              fetch_oob   <= 1'b1;
            end else begin
              if_id.instr    <= {i_mem_data_h, i_mem_data_l};
              if_id.pc       <= pc;
              if_id.pc_plus2 <= 16'(pc + 16'd2);
              if_id.valid    <= 1'b1;
              fetch_count    <= 16'(fetch_count + 16'd1);
            end
          end
          OOB: if_id.valid <= 1'b0;
          default: state <= BOOT;
        endcase
      end
    end
  end

  assign i_mem_addr     = pc;
  assign if_id_instr    = if_id.instr;
  assign if_id_pc       = if_id.pc;
  assign if_id_pc_plus2 = if_id.pc_plus2;
  assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances, the second
// sized to four memory words for the out-of-range scenario.
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    case (a)
      16'h0000: w = 16'h1722;
      16'h0002: w = 16'h1F28;
      16'h0004: w = 16'h1B8A;
      default:  w = {~a[7:0], a[7:0]};
    endcase
    return w;
  endfunction

  logic        reset, stall, redirect;
  logic [15:0] br_target, addr;
  logic [15:0] instr, pc, pc2, cnt;
  logic        valid, mis, oob;
  logic [15:0] word;

  assign word = mem_word(addr);

  instruction_fetch #(.RESET_PC(16'h0000), .IMEM_WORDS(101)) dut (
    .clk(clk), .reset(reset), .i_mem_addr(addr),
    .i_mem_data_h(word[15:8]), .i_mem_data_l(word[7:0]),
    .stall(stall), .redirect(redirect), .br_target(br_target),
    .if_id_instr(instr), .if_id_pc(pc), .if_id_pc_plus2(pc2),
    .if_id_valid(valid), .misalign_err(mis), .fetch_oob(oob),
    .fetch_count(cnt)
  );

  logic        s_reset, s_stall, s_redirect;
  logic [15:0] s_target, s_addr;
  logic [15:0] s_instr, s_pc, s_pc2, s_cnt;
  logic        s_valid, s_mis, s_oob;
  logic [15:0] s_word;

  assign s_word = mem_word(s_addr);

  instruction_fetch #(.RESET_PC(16'h0000), .IMEM_WORDS(4)) u_small (
    .clk(clk), .reset(s_reset), .i_mem_addr(s_addr),
    .i_mem_data_h(s_word[15:8]), .i_mem_data_l(s_word[7:0]),
    .stall(s_stall), .redirect(s_redirect), .br_target(s_target),
    .if_id_instr(s_instr), .if_id_pc(s_pc), .if_id_pc_plus2(s_pc2),
    .if_id_valid(s_valid), .misalign_err(s_mis), .fetch_oob(s_oob),
    .fetch_count(s_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; stall = 0; redirect = 0; br_target = 0;
    step(); step();
    total++;
    if (valid !== 1'b0 || addr !== 16'h0000 || cnt !== 16'h0000) begin
      bad++;
      $display("FAIL reset: valid=%b addr=%h cnt=%h want 0/0000/0000",
               valid, addr, cnt);
    end
    total++;
    if (mis !== 1'b0 || oob !== 1'b0 || pc !== 16'h0 || instr !== 16'h0) begin
      bad++;
      $display("FAIL reset_flags: mis=%b oob=%b pc=%h instr=%h want zeros",
               mis, oob, pc, instr);
    end
  endtask

  task automatic test_fetch();
    logic [15:0] exp_i [3];
    exp_i[0] = 16'h1722; exp_i[1] = 16'h1F28; exp_i[2] = 16'h1B8A;
    reset = 1;
    step();
    total++;
    if (valid !== 1'b0 || addr !== 16'h0000) begin
      bad++;
      $display("FAIL boot: valid=%b addr=%h want 0/0000", valid, addr);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (valid !== 1'b1 || pc !== 16'(2 * k) || instr !== exp_i[k] ||
          pc2 !== 16'(2 * k + 2) || addr !== 16'(2 * k + 2)) begin
        bad++;
        $display("FAIL fetch%0d: v=%b pc=%h i=%h p2=%h a=%h want 1/%h/%h/%h/%h",
                 k, valid, pc, instr, pc2, addr, 16'(2 * k), exp_i[k],
                 16'(2 * k + 2), 16'(2 * k + 2));
      end
    end
    total++;
    if (cnt !== 16'd3) begin
      bad++;
      $display("FAIL count3: cnt=%0d want 3", cnt);
    end
  endtask

  task automatic test_stall();
    step();
    total++;
    if (pc !== 16'h6 || addr !== 16'h8 || cnt !== 16'd4) begin
      bad++;
      $display("FAIL pre_stall: pc=%h addr=%h cnt=%0d want 6/8/4", pc, addr, cnt);
    end
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (pc !== 16'h6 || instr !== 16'hF906 || valid !== 1'b1 ||
          addr !== 16'h8 || cnt !== 16'd4) begin
        bad++;
        $display("FAIL stall%0d: pc=%h i=%h v=%b a=%h cnt=%0d want 6/f906/1/8/4",
                 k, pc, instr, valid, addr, cnt);
      end
    end
    stall = 0;
    step();
    total++;
    if (pc !== 16'h8 || instr !== 16'hF708 || addr !== 16'hA || cnt !== 16'd5) begin
      bad++;
      $display("FAIL post_stall: pc=%h i=%h a=%h cnt=%0d want 8/f708/a/5",
               pc, instr, addr, cnt);
    end
  endtask

  task automatic test_redirect();
    step();
    total++;
    if (addr !== 16'hC || pc !== 16'hA) begin
      bad++;
      $display("FAIL pre_redir: addr=%h pc=%h want c/a", addr, pc);
    end
    redirect = 1; stall = 1; br_target = 16'h001C;
    step();
    redirect = 0; stall = 0;
    total++;
    if (addr !== 16'h1C || valid !== 1'b0 || mis !== 1'b0 || cnt !== 16'd6) begin
      bad++;
      $display("FAIL redir: a=%h v=%b mis=%b cnt=%0d want 1c/0/0/6",
               addr, valid, mis, cnt);
    end
    step();
    total++;
    if (pc !== 16'h1C || pc2 !== 16'h1E || valid !== 1'b1 ||
        instr !== 16'hE31C || cnt !== 16'd7) begin
      bad++;
      $display("FAIL redir_tgt: pc=%h p2=%h v=%b i=%h cnt=%0d want 1c/1e/1/e31c/7",
               pc, pc2, valid, instr, cnt);
    end
  endtask

  task automatic test_misalign();
    redirect = 1; br_target = 16'h0013;
    step();
    redirect = 0;
    total++;
    if (mis !== 1'b1 || addr !== 16'h0012 || valid !== 1'b0) begin
      bad++;
      $display("FAIL misalign: mis=%b a=%h v=%b want 1/0012/0", mis, addr, valid);
    end
    step();
    total++;
    if (mis !== 1'b0 || pc !== 16'h0012 || valid !== 1'b1) begin
      bad++;
      $display("FAIL misalign_end: mis=%b pc=%h v=%b want 0/0012/1", mis, pc, valid);
    end
  endtask

  task automatic test_oob();
    s_reset = 0; s_stall = 0; s_redirect = 0; s_target = 0;
    step();
    s_reset = 1;
    for (int k = 0; k < 5; k++) step();
    total++;
    if (s_pc !== 16'h6 || s_valid !== 1'b1 || s_oob !== 1'b0 || s_cnt !== 16'd4) begin
      bad++;
      $display("FAIL oob_last: pc=%h v=%b oob=%b cnt=%0d want 6/1/0/4",
               s_pc, s_valid, s_oob, s_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (s_oob !== 1'b1 || s_valid !== 1'b0 || s_addr !== 16'h8 || s_cnt !== 16'd4) begin
        bad++;
        $display("FAIL oob%0d: oob=%b v=%b a=%h cnt=%0d want 1/0/8/4",
                 k, s_oob, s_valid, s_addr, s_cnt);
      end
    end
    s_redirect = 1; s_target = 16'h0000;
    step();
    s_redirect = 0;
    total++;
    if (s_oob !== 1'b0 || s_valid !== 1'b0 || s_addr !== 16'h0) begin
      bad++;
      $display("FAIL oob_exit: oob=%b v=%b a=%h want 0/0/0000", s_oob, s_valid, s_addr);
    end
    step();
    total++;
    if (s_valid !== 1'b1 || s_pc !== 16'h0 || s_instr !== 16'h1722 || s_cnt !== 16'd5) begin
      bad++;
      $display("FAIL oob_resume: v=%b pc=%h i=%h cnt=%0d want 1/0000/1722/5",
               s_valid, s_pc, s_instr, s_cnt);
    end
  endtask

  task automatic test_reset_mid();
    redirect = 1; br_target = 16'h0033; reset = 0;
    step();
    redirect = 0;
    total++;
    if (addr !== 16'h0 || valid !== 1'b0 || cnt !== 16'h0 || mis !== 1'b0 ||
        oob !== 1'b0 || pc !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: a=%h v=%b cnt=%h mis=%b oob=%b pc=%h want zeros",
               addr, valid, cnt, mis, oob, pc);
    end
    reset = 1;
    step();
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL reboot: v=%b want 0", valid);
    end
    step();
    total++;
    if (valid !== 1'b1 || instr !== 16'h1722 || cnt !== 16'd1) begin
      bad++;
      $display("FAIL reboot_fetch: v=%b i=%h cnt=%0d want 1/1722/1", valid, instr, cnt);
    end
  endtask

  initial begin
    s_reset = 0; s_stall = 0; s_redirect = 0; s_target = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_misalign();
    test_oob();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
